// File: rtl/serial_arith_pkg.sv
// Shared types and helpers for the bit-serial arithmetic units.
// Holds the sequencing state encoding and the bit-counter width rule.
// No logic; imported by the serial datapath modules.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit counter must index 0..W-1, and never collapse to zero width for W = 1.
    function automatic int cnt_width(input int w);
        int cw;
        cw = $clog2(w);
        return (cw < 1) ? 1 : cw;
    endfunction

endpackage

// File: rtl/full_sub_cell.sv
// One-bit full subtractor: d = x - y - c, bo = borrow out.
// Purely combinational, zero latency.
// No handshake; the caller sequences it.
module full_sub_cell (
    input  logic x,
    input  logic y,
    input  logic c,
    output logic d,
    output logic bo
);

    assign d  = x ^ y ^ c;
    assign bo = (~x & y) | (~(x ^ y) & c);

endmodule

// File: rtl/serial_sub_unit.sv
// Bit-serial W-bit subtractor: diff = a - b - bin, LSB first, one cell + borrow flop.
// Latency: accept edge, then W RUN edges; out_valid rises on the W-th RUN edge.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE.
module serial_sub_unit
    import serial_arith_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] diff,
    output logic         bout
);

    localparam int            CW   = cnt_width(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [W-1:0]  a_sr;
    logic [W-1:0]  b_sr;
    logic          brw;
    logic          cell_d;
    logic          cell_bo;
    logic [W-1:0]  diff_shift;

    full_sub_cell u_cell (
        .x  (a_sr[0]),
        .y  (b_sr[0]),
        .c  (brw),
        .d  (cell_d),
        .bo (cell_bo)
    );

    // New bit enters at the MSB so that after W shifts bit 0 lands at diff[0].
    always_comb begin
        diff_shift        = diff >> 1;
        diff_shift[W-1]   = cell_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            diff      <= '0;
            bout      <= 1'b0;
            cnt       <= '0;
            brw       <= 1'b0;
            a_sr      <= '0;
            b_sr      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_sr     <= a;
                        b_sr     <= b;
                        brw      <= bin;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    diff <= diff_shift;
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    brw  <= cell_bo;
                    if (cnt == LAST) begin
                        bout      <= cell_bo;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub_unit.sv
// Directed and randomized bench for serial_sub_unit at W = 8, 16 and 1.
// Expected {bout, diff} values are queued at issue time and compared on completion.
module tb_serial_sub_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   checks = 0;
    int   errors = 0;

    logic        iv8, ir8, bin8, ov8, or8, bo8;
    logic [7:0]  a8, b8, d8;
    logic        iv16, ir16, bin16, ov16, or16, bo16;
    logic [15:0] a16, b16, d16;
    logic        iv1, ir1, bin1, ov1, or1, bo1;
    logic [0:0]  a1, b1, d1;

    logic [8:0]  q8[$];
    logic [16:0] q16[$];
    logic [1:0]  q1[$];

    serial_sub_unit #(.W(8)) u_w8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .bin(bin8),
        .out_valid(ov8), .out_ready(or8), .diff(d8), .bout(bo8)
    );
    serial_sub_unit #(.W(16)) u_w16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16), .bin(bin16),
        .out_valid(ov16), .out_ready(or16), .diff(d16), .bout(bo16)
    );
    serial_sub_unit #(.W(1)) u_w1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .bin(bin1),
        .out_valid(ov1), .out_ready(or1), .diff(d1), .bout(bo1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One W=8 operation; optional in_valid noise during RUN and a DONE stall of 'hold' cycles.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                       input bit noise, input int hold);
        logic [8:0] exp;
        int n;
        check("w8_ready_idle", ir8, 1);
        a8 = a; b8 = b; bin8 = bin; iv8 = 1'b1;
        q8.push_back({1'b0, a} - {1'b0, b} - 9'(bin));
        tick;
        iv8 = 1'b0;
        check("w8_ready_run", ir8, 0);
        n = 0;
        while (!ov8 && n < 50) begin
            if (noise) begin
                iv8 = ~iv8; a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
                check("w8_ready_noise", ir8, 0);
            end
            tick;
            n++;
        end
        iv8 = 1'b0;
        check("w8_latency", n, 8);
        exp = q8.pop_front();
        check("w8_result", {bo8, d8}, exp);
        for (int i = 0; i < hold; i++) begin
            tick;
            check("w8_hold_result", {bo8, d8}, exp);
            check("w8_hold_valid", ov8, 1);
            check("w8_hold_ready", ir8, 0);
        end
        or8 = 1'b1;
        tick;
        or8 = 1'b0;
        check("w8_release_ready", ir8, 1);
        check("w8_release_valid", ov8, 0);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        iv8 = 0; or8 = 0; a8 = 0; b8 = 0; bin8 = 0;
        iv16 = 0; or16 = 0; a16 = 0; b16 = 0; bin16 = 0;
        iv1 = 0; or1 = 0; a1 = 0; b1 = 0; bin1 = 0;
        #1;
        check("rst_ready", ir8, 1);
        check("rst_valid", ov8, 0);
        check("rst_diff", d8, 0);
        check("rst_bout", bo8, 0);
        #11 rst = 1'b0;
        tick;

        op8(8'h5A, 8'h3C, 1'b0, 1'b0, 0);
        op8(8'h00, 8'h01, 1'b0, 1'b0, 0);
        op8(8'hFF, 8'hFF, 1'b1, 1'b0, 0);
        op8(8'h10, 8'h01, 1'b0, 1'b0, 20);
        op8(8'h33, 8'h11, 1'b0, 1'b1, 0);

        // Abort on RUN cycle 4: reset must clear outputs without waiting for an edge.
        a8 = 8'h12; b8 = 8'h34; bin8 = 1'b0; iv8 = 1'b1;
        tick;
        iv8 = 1'b0;
        tick; tick; tick;
        check("abort_prerst_valid", ov8, 0);
        #2 rst = 1'b1;
        #1;
        check("abort_valid", ov8, 0);
        check("abort_ready", ir8, 1);
        check("abort_diff", d8, 0);
        check("abort_bout", bo8, 0);
        tick;
        rst = 1'b0;
        tick;
        op8(8'h80, 8'h7F, 1'b0, 1'b0, 0);

        for (int i = 0; i < 1000; i++) begin
            check("w16_ready", ir16, 1);
            a16 = 16'($urandom); b16 = 16'($urandom); bin16 = 1'($urandom); iv16 = 1'b1;
            q16.push_back({1'b0, a16} - {1'b0, b16} - 17'(bin16));
            tick;
            iv16 = 1'b0;
            n = 0;
            while (!ov16 && n < 100) begin
                tick;
                n++;
            end
            check("w16_latency", n, 16);
            check("w16_result", {bo16, d16}, q16.pop_front());
            or16 = 1'b1;
            tick;
            or16 = 1'b0;
        end

        for (int i = 0; i < 1000; i++) begin
            check("w1_ready", ir1, 1);
            a1 = 1'($urandom); b1 = 1'($urandom); bin1 = 1'($urandom); iv1 = 1'b1;
            q1.push_back({1'b0, a1} - {1'b0, b1} - 2'(bin1));
            tick;
            iv1 = 1'b0;
            n = 0;
            while (!ov1 && n < 20) begin
                tick;
                n++;
            end
            check("w1_latency", n, 1);
            check("w1_result", {bo1, d1}, q1.pop_front());
            or1 = 1'b1;
            tick;
            or1 = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
